// File: rtl/iobuf_pair_loader.sv
// Ping-pong input buffer: loads N serial complex samples per frame into one of
// two banks and drains each frame as N/2 pairs {x[k], x[k+N/2]}.
// Optional build macro IOBUF_BITREV_EN stores each frame in bit-reversed order.
module iobuf_pair_loader #(
  parameter int N  = 64,
  parameter int DW = 64,
  parameter int AW = 6
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] IN_DATA,
  input  logic          IN_LAST,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] D0_IOBUF,
  output logic [DW-1:0] D1_IOBUF,
  output logic          OUT_LAST,
  output logic          ERR_LAST
);

  // Both banks live in one array; the bank bit is the address MSB.
  logic [DW-1:0] r_mem [2*N];

  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-2:0] r_rd_cnt;
  logic [1:0]    r_full;
  logic          r_err_last;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_out_valid;
  logic          w_xfer;
  logic          w_wr_last;
  logic          w_rd_last;
  logic [AW-1:0] w_wr_addr;
  logic [1:0]    w_full_nxt;

  function automatic logic [AW-1:0] f_bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
    return r;
  endfunction

  assign w_in_ready  = !RST && !r_full[r_wr_bank];
  assign w_accept    = IN_VALID && w_in_ready;
  assign w_out_valid = r_full[r_rd_bank];
  assign w_xfer      = w_out_valid && OUT_READY;
  assign w_wr_last   = (r_wr_cnt == AW'(N-1));
  assign w_rd_last   = (r_rd_cnt == {(AW-1){1'b1}});

`ifdef IOBUF_BITREV_EN
  assign w_wr_addr = f_bitrev(r_wr_cnt);
`else
  assign w_wr_addr = r_wr_cnt;
`endif

  // Write and read completing on the same edge always hit different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_accept && w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_xfer && w_rd_last)   w_full_nxt[r_rd_bank] = 1'b0;
  end

  // Sample storage: data path, never reset.
  always_ff @(posedge CLK) begin
    if (w_accept) r_mem[{r_wr_bank, w_wr_addr}] <= IN_DATA;
  end

  // Write-side control.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_bank  <= 1'b0;
      r_wr_cnt   <= '0;
      r_err_last <= 1'b0;
    end else if (w_accept) begin
      if (IN_LAST != w_wr_last) r_err_last <= 1'b1;
      if (w_wr_last) begin
        r_wr_cnt  <= '0;
        r_wr_bank <= !r_wr_bank;
      end else begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
      end
    end
  end

  // Read-side control.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_bank <= 1'b0;
      r_rd_cnt  <= '0;
    end else if (w_xfer) begin
      if (w_rd_last) begin
        r_rd_cnt  <= '0;
        r_rd_bank <= !r_rd_bank;
      end else begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_full <= 2'b00;
    else     r_full <= w_full_nxt;
  end

  assign IN_READY  = w_in_ready;
  assign OUT_VALID = w_out_valid;
  assign OUT_LAST  = w_out_valid && w_rd_last;
  assign ERR_LAST  = r_err_last;
  assign D0_IOBUF  = w_out_valid ? r_mem[{r_rd_bank, 1'b0, r_rd_cnt}] : '0;
  assign D1_IOBUF  = w_out_valid ? r_mem[{r_rd_bank, 1'b1, r_rd_cnt}] : '0;

endmodule

// File: tb/tb_iobuf_pair_loader.sv
// Directed bench for iobuf_pair_loader at N=8: reset, natural order, ping-pong,
// backpressure, ERR_LAST and mid-frame reset, with hand-written pair orders.
module tb_iobuf_pair_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [63:0] IN_DATA = '0;
  logic        IN_LAST = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [63:0] D0_IOBUF;
  logic [63:0] D1_IOBUF;
  logic        OUT_LAST;
  logic        ERR_LAST;

  iobuf_pair_loader #(.N(8), .DW(64), .AW(3)) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .D0_IOBUF(D0_IOBUF), .D1_IOBUF(D1_IOBUF), .OUT_LAST(OUT_LAST), .ERR_LAST(ERR_LAST)
  );

  always #5 CLK = ~CLK;

  // Sample index held at bank address a (D0 reads a=k, D1 reads a=k+4).
`ifdef IOBUF_BITREV_EN
  localparam int ORD [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  localparam int ORD [8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif

  typedef struct packed {
    logic [63:0] d0;
    logic [63:0] d1;
    logic        last;
  } pair_t;

  pair_t q[$];
  int    n_chk = 0;
  int    n_err = 0;
  logic  exp_err = 1'b0;

  function automatic logic [63:0] mk(input int v);
    return {32'h1000_0000 + 32'(v), 32'hFFFF_0000 | 32'(v)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_frame(input int base);
    pair_t p;
    for (int k = 0; k < 4; k++) begin
      p.d0   = mk(base + ORD[k]);
      p.d1   = mk(base + ORD[k+4]);
      p.last = (k == 3);
      q.push_back(p);
    end
  endtask

  // Streams cnt samples from base, drains pairs against q.
  // mode 0: OUT_READY=1; mode 1: OUT_READY toggles each clock.
  task automatic run(input int base, input int cnt, input int mode, input int lastpos);
    int          i = 0;
    int          cyc = 0;
    bit          hold = 0;
    logic [63:0] h0 = '0, h1 = '0;
    logic        hl = 1'b0;
    pair_t       p;
    while ((i < cnt || q.size() > 0) && cyc < 300) begin
      IN_VALID  = (i < cnt);
      IN_DATA   = mk(base + i);
      IN_LAST   = (i < cnt) && ((i % 8) == lastpos);
      OUT_READY = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      @(negedge CLK);
      chk("err_last", ERR_LAST, exp_err);
      if (hold) begin
        chk("hold_vld", OUT_VALID, 1);
        chk("hold_d0", D0_IOBUF, h0);
        chk("hold_d1", D1_IOBUF, h1);
        chk("hold_last", OUT_LAST, hl);
      end
      hold = OUT_VALID && !OUT_READY;
      h0 = D0_IOBUF; h1 = D1_IOBUF; hl = OUT_LAST;
      if (IN_VALID && IN_READY) begin
        if (IN_LAST != ((i % 8) == 7)) exp_err = 1'b1;
        i++;
      end
      if (OUT_VALID && OUT_READY) begin
        if (q.size() == 0) begin
          chk("extra_pair", 1, 0);
        end else begin
          p = q.pop_front();
          chk("pair_d0", D0_IOBUF, p.d0);
          chk("pair_d1", D1_IOBUF, p.d1);
          chk("pair_last", OUT_LAST, p.last);
        end
      end
      step();
      cyc++;
    end
    IN_VALID  = 1'b0;
    IN_LAST   = 1'b0;
    OUT_READY = 1'b0;
    if (cyc >= 300) chk("timeout", 64'(cyc), 0);
    @(negedge CLK);
    chk("drained", OUT_VALID, 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_last", OUT_LAST, 0);
    chk("rst_d0", D0_IOBUF, 0);
    chk("rst_d1", D1_IOBUF, 0);
    chk("rst_err", ERR_LAST, 0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("rel_in_ready", IN_READY, 1);
    step();

    // Natural order, one frame, exact latency
    OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      IN_VALID = 1'b1;
      IN_DATA  = mk(i);
      IN_LAST  = (i == 7);
      @(negedge CLK);
      chk("nat_in_ready", IN_READY, 1);
      chk("nat_pre_vld", OUT_VALID, 0);
      step();
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("nat_vld", OUT_VALID, 1);
      chk("nat_d0", D0_IOBUF, mk(ORD[k]));
      chk("nat_d1", D1_IOBUF, mk(ORD[k+4]));
      chk("nat_last", OUT_LAST, (k == 3));
      step();
    end
    @(negedge CLK);
    chk("nat_done", OUT_VALID, 0);
    chk("nat_d0_zero", D0_IOBUF, 0);
    chk("nat_err", ERR_LAST, 0);
    step();

    // Ping-pong: fill both banks with OUT_READY low
    OUT_READY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      IN_VALID = 1'b1;
      IN_DATA  = mk(i);
      IN_LAST  = ((i % 8) == 7);
      @(negedge CLK);
      chk("pp_in_ready", IN_READY, 1);
      if (i == 8) chk("pp_first_vld", OUT_VALID, 1);
      step();
    end
    IN_DATA = mk(16);
    IN_LAST = 1'b0;
    @(negedge CLK);
    chk("pp_full", IN_READY, 0);
    chk("pp_vld", OUT_VALID, 1);
    chk("pp_first_d0", D0_IOBUF, mk(ORD[0]));
    chk("pp_first_d1", D1_IOBUF, mk(ORD[4]));
    step();
    OUT_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("pp_stall", IN_READY, 0);
      chk("pp_d0", D0_IOBUF, mk(ORD[k]));
      chk("pp_d1", D1_IOBUF, mk(ORD[k+4]));
      chk("pp_last", OUT_LAST, (k == 3));
      step();
    end
    @(negedge CLK);
    chk("pp_free", IN_READY, 1);
    chk("pp_next_d0", D0_IOBUF, mk(8 + ORD[0]));
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    step();
    expect_frame(8);
    expect_frame(16);
    run(16, 8, 0, 7);

    // Backpressure: OUT_READY toggling
    expect_frame(100);
    expect_frame(108);
    run(100, 16, 1, 7);

    // ERR_LAST: IN_LAST on sample 5
    expect_frame(200);
    run(200, 8, 0, 5);
    chk("err_set", ERR_LAST, 1);
    expect_frame(208);
    run(208, 8, 1, 7);
    chk("err_sticky", ERR_LAST, 1);

    // Reset mid-frame
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1;
      IN_DATA  = mk(300 + i);
      IN_LAST  = 1'b0;
      step();
    end
    IN_VALID = 1'b0;
    RST = 1'b1;
    #2;
    chk("mid_rst_in_ready", IN_READY, 0);
    chk("mid_rst_vld", OUT_VALID, 0);
    chk("mid_rst_err", ERR_LAST, 0);
    step();
    RST = 1'b0;
    exp_err = 1'b0;
    @(negedge CLK);
    chk("mid_rel_ready", IN_READY, 1);
    step();
    expect_frame(0);
    run(0, 8, 0, 7);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
